// File: rtl/uart_receiver_paritychk.sv
// 8N1 / 8E1 UART receiver: 2-FF synchroniser, mid-bit sampling from one wrapping
// baud counter, optional even-parity check, stop-bit check with break handling.
module uart_receiver_paritychk #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rx_i,
  input  logic       parity_en,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       busy_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_en_q, par_en_d;
  logic          perr_q, perr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_out_q, perr_out_d;
  logic          ferr_q, ferr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d  = START;
          par_en_d = parity_en;
          idx_d    = '0;
        end
      end
      START: if (cnt_q == CNT_MID) begin
        // Start bit still low at mid-bit: real frame; otherwise a glitch.
        if (!rx_s_q) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (cnt_q == CNT_LAST) begin
        shift_d = {rx_s_q, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (cnt_q == CNT_LAST) begin
        perr_d  = ^{shift_q, rx_s_q};
        state_d = STOP;
      end
      STOP: if (cnt_q == CNT_LAST) begin
        data_d     = shift_q;
        valid_d    = 1'b1;
        perr_out_d = par_en_q & perr_q;
        ferr_d     = ~rx_s_q;
        // A low stop bit may be a break; hold off until the line idles again.
        state_d    = rx_s_q ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: if (rx_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= rx_i;
      rx_s_q     <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_q;
  assign busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver_paritychk.sv
// Randomised frame stimulus against a frame-level scoreboard for uart_receiver_paritychk.
module tb_uart_receiver_paritychk;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       rx_i = 1'b1;
  logic       parity_en = 1'b0;
  logic [7:0] data_o;
  logic       data_valid_o, parity_err_o, frame_err_o, busy_o;

  uart_receiver_paritychk #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .n_rst(n_rst), .rx_i(rx_i), .parity_en(parity_en),
    .data_o(data_o), .data_valid_o(data_valid_o), .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         pulses = 0;
  int         exp_pulses = 0;
  int         last_valid_cyc = -1;
  logic       prev_valid = 1'b0;
  logic [7:0] exp_last_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each valid pulse must match the oldest outstanding frame.
  always @(negedge clk) begin
    if (data_valid_o) begin
      exp_t e;
      pulses++;
      last_valid_cyc = cyc;
      chk("pulse_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("data", {24'd0, data_o}, {24'd0, e.d});
        chk("parity_err", {31'd0, parity_err_o}, {31'd0, e.pe});
        chk("frame_err", {31'd0, frame_err_o}, {31'd0, e.fe});
        exp_last_data = e.d;
      end
    end
    prev_valid = data_valid_o;
  end

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  {24'd0, data_o}, 32'd0);
    chk({tag, "_valid"}, {31'd0, data_valid_o}, 32'd0);
    chk({tag, "_perr"},  {31'd0, parity_err_o}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, frame_err_o}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
  endtask

  // Sends one frame. pen selects a parity bit (value pbit, may be wrong on purpose),
  // hold_bits keeps the line low after a low stop bit, abort resets during data bit 4.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int hold_bits, input int gap,
                            input logic abort, output int start_cyc);
    exp_t e;
    logic [7:0] dd;
    dd = d;
    if (!abort) begin
      e.d  = d;
      // even parity: total ones over data and parity bit must be even
      e.pe = pen && ($countones({d, pbit}) % 2 == 1);
      e.fe = !stop;
      exp_q.push_back(e);
      exp_pulses++;
    end
    parity_en = pen;
    start_cyc = cyc;
    drive_bit(1'b0);
    // mid-frame changes of parity_en must be ignored
    parity_en = logic'($urandom_range(0, 1));
    for (int i = 0; i < 8; i++) begin
      if (abort && i == 4) begin
        rx_i = dd[i];
        repeat (CPB / 2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk_reset_outputs("abort_rst");
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        exp_last_data = 8'h00;
        idle(gap);
        return;
      end
      drive_bit(dd[i]);
    end
    if (pen) drive_bit(pbit);
    drive_bit(stop);
    if (!stop) begin
      for (int i = 0; i < hold_bits; i++) begin
        drive_bit(1'b0);
        chk("break_busy", {31'd0, busy_o}, 32'd1);
      end
    end
    idle(gap);
  endtask

  initial begin
    int sc;
    int p0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    n_rst = 1'b1;
    idle(5);
    chk("post_reset_busy", {31'd0, busy_o}, 32'd0);

    // 0xA5, no parity; pulse lands 2 sync + half bit + 9 bits + output register after the edge
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, 10, 1'b0, sc);
    chk("latency_a5", last_valid_cyc - sc, CPB / 2 + 9 * CPB + 3);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 0, 10, 1'b0, sc);
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 0, 10, 1'b0, sc);

    // break: low stop bit, line held low for 40 more bit times
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 40, 6, 1'b0, sc);
    chk("break_idle", {31'd0, busy_o}, 32'd0);

    // 3-clock glitch must not produce a frame
    p0 = pulses;
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_i = 1'b1;
    chk("glitch_busy_rise", {31'd0, busy_o}, 32'd1);
    idle(CPB + 4);
    chk("glitch_busy_fall", {31'd0, busy_o}, 32'd0);
    chk("glitch_no_pulse", pulses - p0, 32'd0);
    chk("glitch_data_held", {24'd0, data_o}, {24'd0, exp_last_data});

    // back-to-back frames with no idle gap
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, sc);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 0, 10, 1'b0, sc);

    // reset mid-frame, then a clean frame
    p0 = pulses;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 0, 10, 1'b1, sc);
    chk("abort_no_pulse", pulses - p0, 32'd0);
    chk_reset_outputs("abort_after");
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 0, 10, 1'b0, sc);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic pen, pbit, stop;
      int gap;
      d    = 8'($urandom);
      pen  = logic'($urandom_range(0, 1));
      pbit = logic'($urandom_range(0, 1));
      stop = ($urandom_range(0, 7) != 0);
      gap  = stop ? int'($urandom_range(0, 20)) : int'($urandom_range(2, 20));
      send_frame(d, pen, pbit, stop, stop ? 0 : int'($urandom_range(0, 3)), gap, 1'b0, sc);
    end

    idle(3 * CPB);
    chk("pulse_count", pulses, exp_pulses);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("final_busy", {31'd0, busy_o}, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
